// File: rtl/serial_seq_tx.sv
// Serial bit-sequence transmitter: captures a pattern on start and shifts it out
// MSB-first for a programmable number of back-to-back passes, all outputs registered.
module serial_seq_tx #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_pattern,
   input  logic [LEN_W-1:0] i_len,
   input  logic [REP_W-1:0] i_reps,
   output logic             o_x,
   output logic             o_x_valid,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_pat;
   logic [LEN_W-1:0] r_idx;
   logic [LEN_W-1:0] r_len_m1;
   logic [REP_W-1:0] r_pass;
   logic             r_x;
   logic             r_x_valid;
   logic             r_busy;
   logic             r_done;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_pat_nxt;
   logic [LEN_W-1:0] w_idx_nxt;
   logic [LEN_W-1:0] w_len_m1_nxt;
   logic [REP_W-1:0] w_pass_nxt;
   logic [LEN_W-1:0] w_len_eff;
   logic [REP_W-1:0] w_pass_m1;
   logic [WIDTH-1:0] w_shifted;

   // Resolve the effective length and pass count of a start request.
   always_comb begin
      w_len_eff = i_len;
      w_pass_m1 = REP_ZERO;
      if ((i_len == LEN_ZERO) || (i_len > LEN_MAX)) begin
         w_len_eff = LEN_MAX;
      end else begin
         w_len_eff = i_len;
      end
      if (i_reps == REP_ZERO) begin
         w_pass_m1 = REP_ZERO;
      end else begin
         w_pass_m1 = i_reps - REP_ONE;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_pat_nxt    = r_pat;
      w_idx_nxt    = r_idx;
      w_len_m1_nxt = r_len_m1;
      w_pass_nxt   = r_pass;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt  = S_SHIFT;
               w_pat_nxt    = i_pattern;
               w_len_m1_nxt = w_len_eff - LEN_ONE;
               w_idx_nxt    = w_len_eff - LEN_ONE;
               w_pass_nxt   = w_pass_m1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (r_idx != LEN_ZERO) begin
               w_idx_nxt = r_idx - LEN_ONE;
            end else if (r_pass != REP_ZERO) begin
               // Next pass starts on the very next cycle, no gap.
               w_idx_nxt  = r_len_m1;
               w_pass_nxt = r_pass - REP_ONE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are computed from next state so they leave a register.
   assign w_shifted = w_pat_nxt >> w_idx_nxt;

   // State, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_pat     <= {WIDTH{1'b0}};
         r_idx     <= LEN_ZERO;
         r_len_m1  <= LEN_ZERO;
         r_pass    <= REP_ZERO;
         r_x       <= 1'b0;
         r_x_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pat     <= w_pat_nxt;
         r_idx     <= w_idx_nxt;
         r_len_m1  <= w_len_m1_nxt;
         r_pass    <= w_pass_nxt;
         r_x       <= (w_state_nxt == S_SHIFT) ? w_shifted[0] : 1'b0;
         r_x_valid <= (w_state_nxt == S_SHIFT);
         r_busy    <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_DONE);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   assign o_x       = r_x;
   assign o_x_valid = r_x_valid;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_serial_seq_tx.sv
// Scoreboard bench for serial_seq_tx: expected {x,x_valid,busy,done} per cycle
// are queued when stimulus is driven and checked one entry per clock.
module tb_serial_seq_tx;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] pattern;
   logic [3:0] len;
   logic [3:0] reps;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       done;

   logic [3:0] exp_q[$];
   int         total;
   int         bad;

   serial_seq_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_start   (start),
      .i_pattern (pattern),
      .i_len     (len),
      .i_reps    (reps),
      .o_x       (x),
      .o_x_valid (x_valid),
      .o_busy    (busy),
      .o_done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each cycle after the edge, compare the outputs with the oldest expectation.
   always @(posedge clk) begin
      logic [3:0] got;
      logic [3:0] want;
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = {x, x_valid, busy, done};
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL out_cycle t=%0t got{x,v,busy,done}=%b required=%b", $time, got, want);
         end
      end
   end

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
   endtask

   task automatic push_frame(input logic [7:0] pat, input int len_eff, input int passes);
      for (int p = 0; p < passes; p++)
         for (int b = len_eff - 1; b >= 0; b--)
            exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      exp_q.push_back(4'b0011);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout remaining=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic send(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] r);
      @(negedge clk);
      start   = 1'b1;
      pattern = pat;
      len     = l;
      reps    = r;
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      start   = 1'b1;
      pattern = 8'hFF;
      len     = 4'd8;
      reps    = 4'd1;
      push_idle(4);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      wait_drain("reset");
   endtask

   task automatic test_detector;
      send(8'b0010_1101, 4'd6, 4'd1);
      push_frame(8'b0010_1101, 6, 1);
      push_idle(1);
      @(negedge clk);
      start = 1'b0;
      wait_drain("detector");
   endtask

   task automatic test_defaults;
      send(8'hA5, 4'd0, 4'd2);
      push_frame(8'hA5, 8, 2);
      push_idle(1);
      @(negedge clk);
      start = 1'b0;
      wait_drain("default_len");
      send(8'h3C, 4'd9, 4'd0);
      push_frame(8'h3C, 8, 1);
      push_idle(1);
      @(negedge clk);
      start = 1'b0;
      wait_drain("default_reps");
   endtask

   task automatic test_busy;
      send(8'hF0, 4'd8, 4'd1);
      push_frame(8'hF0, 8, 1);
      push_idle(3);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start   = 1'b1;
      pattern = 8'h0F;
      len     = 4'd4;
      reps    = 4'd3;
      @(negedge clk);
      start = 1'b0;
      wait_drain("busy");
   endtask

   task automatic test_reset_mid;
      send(8'hC3, 4'd8, 4'd1);
      exp_q.push_back(4'b1110);
      exp_q.push_back(4'b1110);
      exp_q.push_back(4'b0110);
      push_idle(3);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start   = 1'b1;
      pattern = 8'h5A;
      len     = 4'd8;
      reps    = 4'd1;
      push_frame(8'h5A, 8, 1);
      push_idle(1);
      @(negedge clk);
      start = 1'b0;
      wait_drain("reset_mid");
   endtask

   task automatic test_back_to_back;
      send(8'b0000_0010, 4'd2, 4'd1);
      for (int k = 0; k < 3; k++) begin
         push_frame(8'b0000_0010, 2, 1);
         push_idle(1);
      end
      push_idle(1);
      repeat (12) @(negedge clk);
      start = 1'b0;
      wait_drain("back_to_back");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_detector();
      test_defaults();
      test_busy();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_seq_tx.md
# serial_seq_tx

Serial bit-sequence transmitter: the driving end of the single-bit `x` stream consumed by the Moore sequence-detector FSMs. It captures a parallel pattern on a `start` request and shifts it out MSB-first, one bit per clock, for a programmable number of back-to-back passes. All outputs are registered (Moore style). Detector testbenches and the on-chip self-test path use it in place of hand-written `#10 x = ...` stimulus.

## Interface
- `WIDTH`, 8: pattern register width in bits.
- `LEN_W`, 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `REP_W`, 4: width of `reps`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the rising edge where it is sampled high.
- `start` in 1: request to send; sampled only in IDLE.
- `pattern` in WIDTH: bits to send; `pattern[len_eff-1]` goes first, `pattern[0]` goes last.
- `len` in LEN_W: bits per pass; 0 or >WIDTH → `len_eff = WIDTH`.
- `reps` in REP_W: number of passes; 0 → 1 pass.
- `x` out 1: serial data bit; 0 whenever `x_valid` = 0.
- `x_valid` out 1: high on every cycle `x` carries a pattern bit.
- `busy` out 1: high from the first bit cycle through the DONE cycle.
- `done` out 1: one-cycle pulse following the last bit.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `x`=0, `x_valid`=0, `busy`=0, `done`=0. If `start`=1, capture `pattern`, `len_eff` and `passes_eff` into internal registers, load bit index = `len_eff-1` and pass count = `passes_eff-1`, then go to SHIFT.
- SHIFT: `x` = `pat_reg[bit_idx]`, `x_valid`=1, `busy`=1.
  - bit_idx > 0 → decrement bit_idx.
  - bit_idx == 0 and pass count > 0 → reload bit_idx = `len_eff-1`, decrement pass count. Passes run back-to-back with no gap cycle.
  - bit_idx == 0 and pass count == 0 → go to DONE.
- DONE: `x`=0, `x_valid`=0, `busy`=1, `done`=1 for exactly one cycle, then go to IDLE.
- `start`, `pattern`, `len` and `reps` are ignored outside IDLE. Captured values are not affected by input changes after capture.
- Reset: the state machine, counters and pattern register clear. All outputs are 0 on the cycle after the reset edge. Any frame in progress is discarded with no `done`. If `start` and `reset` are high together, `reset` wins and the start request is dropped.
- Total bits per frame = `len_eff` × `passes_eff`; the maximum is WIDTH × (2^REP_W − 1).

## Timing
- `start` sampled high in IDLE at edge 0 → first bit on `x` during cycle 1 (one-cycle latency).
- Bit n (0-based) of the frame appears in cycle 1+n.
- `done`=1 in cycle 1 + `len_eff`·`passes_eff`.
- IDLE again the following cycle; the earliest next accepted `start` is sampled at the end of that cycle.
- No combinational path from any input to any output.

## Test plan
- **Reset hold:** `reset`=1 for 2 cycles with `start`=1 and `pattern`=8'hFF → `x`, `x_valid`, `busy` and `done` all 0 throughout and on the first cycle after reset drops; no frame starts.
- **Detector stimulus:** `pattern`=8'b0010_1101, `len`=6, `reps`=1, 1-cycle `start` pulse → `x` = 1,0,1,1,0,1 in cycles 1–6 with `x_valid`=1; `done`=1 in cycle 7; `busy`=0 in cycle 8.
- **Defaulting and repeats:** `pattern`=8'hA5, `len`=0, `reps`=2 → 16 bits 1010_0101_1010_0101 in cycles 1–16 with no gap; `done` in cycle 17. Then `len`=9, `reps`=0 → 8 bits, 1 pass, `done` in cycle 9.
- **Busy protection:** start frame `pattern`=8'hF0, `len`=8; in cycle 3 assert `start` with `pattern`=8'h0F → output stays 1,1,1,1,0,0,0,0 and no second frame follows.
- **Reset mid-frame:** `reset` sampled high in cycle 3 of an 8-bit frame → all outputs 0 from cycle 4 and `done` never pulses. A `start` two cycles later sends its full new pattern correctly.
- **Back-to-back frames:** hold `start`=1 continuously with `len`=2, `pattern`=2'b10 → sequence 1,0, then `done`, then an IDLE cycle, then 1,0 again, repeating with period 4.
